// File: rtl/bpsk_sched_pkg.sv
// Shared types and constants for the BPSK frame scheduler.
package bpsk_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SYNC,
      ST_PAY,
      ST_CRC,
      ST_GAP
   } state_e;

   localparam logic [15:0] CRC_POLY          = 16'h1021;
   localparam logic [15:0] CRC_INIT          = 16'hFFFF;
   localparam logic [7:0]  DEF_PREAMBLE_BYTE = 8'h55;
   localparam logic [15:0] DEF_SYNC_WORD     = 16'h1ACF;

   // One byte of CRC-16-CCITT, MSB first, no reflection.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/bpsk_frame_sched_crc.sv
// Byte-wise CRC-16-CCITT accumulator with synchronous clear and enable.
module bpsk_crc16 import bpsk_sched_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q, crc_d;

   // Next CRC: clear wins over a byte update.
   always_comb begin
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = CRC_INIT;
      end else if (en_i) begin
         crc_d = crc16_byte(crc_q, data_i);
      end
   end

   // CRC register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) crc_q <= CRC_INIT;
      else     crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/bpsk_frame_sched.sv
// Frame scheduler for the BPSK transmit path: preamble, sync word, RAM payload,
// optional CRC (build with BPSK_SCHED_CRC_EN), then a baud-counted guard gap.
module bpsk_frame_sched import bpsk_sched_pkg::*; #(
   parameter int unsigned           DATA_WIDTH    = 8,
   parameter int unsigned           ADDR_WIDTH    = 8,
   parameter int unsigned           FRAME_LEN     = 150,
   parameter int unsigned           PREAMBLE_LEN  = 4,
   parameter logic [DATA_WIDTH-1:0] PREAMBLE_BYTE = DATA_WIDTH'(DEF_PREAMBLE_BYTE),
   parameter logic [15:0]           SYNC_WORD     = DEF_SYNC_WORD,
   parameter int unsigned           GAP_BAUDS     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [7:0]            repeat_cnt,
   input  logic                  baud_tick,
   input  logic                  byte_req,
   output logic [DATA_WIDTH-1:0] byte_out,
   output logic                  byte_valid,
   output logic                  ram_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  tx_en,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            frame_cnt,
   output logic                  ovr
);

   localparam int unsigned IDX_MAX = (FRAME_LEN > PREAMBLE_LEN) ? FRAME_LEN : PREAMBLE_LEN;
   localparam int unsigned IDX_W   = $clog2(IDX_MAX + 3);
   localparam int unsigned GAP_W   = $clog2(GAP_BAUDS + 1);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [GAP_W-1:0]       gap_q, gap_d;
   logic [ADDR_WIDTH-1:0]  base_q, base_d;
   logic [7:0]             rep_q, rep_d;
   logic                   stop_pend_q, stop_pend_d;
   logic                   s1_q, s1_d;
   logic                   s1_pay_q, s1_pay_d;
   logic [DATA_WIDTH-1:0]  s1_byte_q, s1_byte_d;
   logic                   valid_q, valid_d;
   logic                   sel_q, sel_d;
   logic [DATA_WIDTH-1:0]  byte_q, byte_d;
   logic                   ram_en_q, ram_en_d;
   logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
   logic                   tx_en_q, tx_en_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [7:0]             frame_cnt_q, frame_cnt_d;
   logic                   ovr_q, ovr_d;

   logic byte_st_c, pend_c, req_ok_c, end_frame_c;

`ifdef BPSK_SCHED_CRC_EN
   logic [15:0] crc_c;
   logic        crc_clr_c;

   assign crc_clr_c = (state_d == ST_PRE) && (state_q != ST_PRE);

   bpsk_crc16 u_crc (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (crc_clr_c),
      .en_i   (sel_q),
      .data_i (8'(ram_rd_data)),
      .crc_o  (crc_c)
   );
`endif

   assign byte_st_c = (state_q inside {ST_PRE, ST_SYNC, ST_PAY, ST_CRC});
   assign pend_c    = s1_q | valid_q;
   assign req_ok_c  = byte_req & byte_st_c & ~pend_c;

   // Next-state, byte pipeline and output decode.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      gap_d       = gap_q;
      base_d      = base_q;
      rep_d       = rep_q;
      stop_pend_d = stop_pend_q;
      s1_d        = 1'b0;
      s1_pay_d    = 1'b0;
      s1_byte_d   = s1_byte_q;
      valid_d     = s1_q;
      sel_d       = s1_q & s1_pay_q;
      byte_d      = byte_q;
      ram_en_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
      ovr_d       = ovr_q;
      end_frame_c = 1'b0;

      if (s1_q && !s1_pay_q) byte_d = s1_byte_q;
      else if (sel_q)        byte_d = ram_rd_data;

      if (stop && (state_q != ST_IDLE)) stop_pend_d = 1'b1;
      if (byte_req && byte_st_c && pend_c) ovr_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d      = base_addr;
               rep_d       = repeat_cnt;
               frame_cnt_d = '0;
               ovr_d       = 1'b0;
               idx_d       = '0;
               state_d     = ST_PRE;
            end
         end
         ST_PRE: begin
            if (req_ok_c) begin
               s1_d      = 1'b1;
               s1_byte_d = PREAMBLE_BYTE;
               if (idx_q == IDX_W'(PREAMBLE_LEN - 1)) begin
                  idx_d   = '0;
                  state_d = ST_SYNC;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_SYNC: begin
            if (req_ok_c) begin
               s1_d = 1'b1;
               if (idx_q == '0) begin
                  s1_byte_d = DATA_WIDTH'(SYNC_WORD[15:8]);
                  idx_d     = IDX_W'(1);
               end else begin
                  s1_byte_d = DATA_WIDTH'(SYNC_WORD[7:0]);
                  idx_d     = '0;
                  state_d   = ST_PAY;
               end
            end
         end
         ST_PAY: begin
            if (req_ok_c) begin
               if (idx_q == IDX_W'(FRAME_LEN)) begin
                  end_frame_c = 1'b1;
               end else begin
                  s1_d       = 1'b1;
                  s1_pay_d   = 1'b1;
                  ram_en_d   = 1'b1;
                  ram_addr_d = base_q + ADDR_WIDTH'(idx_q);
                  idx_d      = idx_q + 1'b1;
`ifdef BPSK_SCHED_CRC_EN
                  if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                     idx_d   = '0;
                     state_d = ST_CRC;
                  end
`endif
               end
            end
         end
`ifdef BPSK_SCHED_CRC_EN
         ST_CRC: begin
            if (req_ok_c) begin
               if (idx_q == IDX_W'(2)) begin
                  end_frame_c = 1'b1;
               end else begin
                  s1_d      = 1'b1;
                  s1_byte_d = (idx_q == '0) ? DATA_WIDTH'(crc_c[15:8]) : DATA_WIDTH'(crc_c[7:0]);
                  idx_d     = idx_q + 1'b1;
               end
            end
         end
`endif
         ST_GAP: begin
            if (baud_tick) begin
               if (gap_q == GAP_W'(GAP_BAUDS - 1)) begin
                  gap_d = '0;
                  if (stop_pend_q || stop || ((rep_q != '0) && (frame_cnt_q == rep_q))) begin
                     state_d = ST_IDLE;
                  end else begin
                     idx_d   = '0;
                     state_d = ST_PRE;
                  end
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The request after the last byte closes the frame without issuing one.
      if (end_frame_c) begin
         state_d     = ST_GAP;
         gap_d       = '0;
         idx_d       = '0;
         frame_cnt_d = frame_cnt_q + 1'b1;
      end

      if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
         stop_pend_d = 1'b0;
         done_d      = 1'b1;
      end

      tx_en_d = (state_d inside {ST_PRE, ST_SYNC, ST_PAY, ST_CRC});
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         gap_q       <= '0;
         base_q      <= '0;
         rep_q       <= '0;
         stop_pend_q <= 1'b0;
         s1_q        <= 1'b0;
         s1_pay_q    <= 1'b0;
         s1_byte_q   <= '0;
         valid_q     <= 1'b0;
         sel_q       <= 1'b0;
         byte_q      <= '0;
         ram_en_q    <= 1'b0;
         ram_addr_q  <= '0;
         tx_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         frame_cnt_q <= '0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         base_q      <= base_d;
         rep_q       <= rep_d;
         stop_pend_q <= stop_pend_d;
         s1_q        <= s1_d;
         s1_pay_q    <= s1_pay_d;
         s1_byte_q   <= s1_byte_d;
         valid_q     <= valid_d;
         sel_q       <= sel_d;
         byte_q      <= byte_d;
         ram_en_q    <= ram_en_d;
         ram_addr_q  <= ram_addr_d;
         tx_en_q     <= tx_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
         ovr_q       <= ovr_d;
      end
   end

   // Payload bytes come straight from the RAM in their valid cycle.
   assign byte_out   = sel_q ? ram_rd_data : byte_q;
   assign byte_valid = valid_q;
   assign ram_en     = ram_en_q;
   assign ram_addr   = ram_addr_q;
   assign tx_en      = tx_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign frame_cnt  = frame_cnt_q;
   assign ovr        = ovr_q;

endmodule

// File: tb/tb_bpsk_frame_sched.sv
// Self-checking bench for bpsk_frame_sched: scenario table plus reset corner case.
module tb_bpsk_frame_sched;

`ifdef BPSK_SCHED_CRC_EN
   localparam int unsigned FL = 9;
   localparam int unsigned CL = 2;
`else
   localparam int unsigned FL = 4;
   localparam int unsigned CL = 0;
`endif
   localparam int unsigned PL = 2;
   localparam int unsigned GB = 5;

   logic       clk = 1'b0;
   logic       rst, start, stop, baud_tick, byte_req;
   logic [7:0] base_addr, repeat_cnt, byte_out, ram_addr, ram_rd_data, frame_cnt;
   logic       byte_valid, ram_en, tx_en, busy, done, ovr;
   logic [7:0] mem [256];
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] base;
      logic [7:0] rep;
      int         stop_frame;
      bit         dbl;
      logic [7:0] exp_frames;
      logic       exp_ovr;
   } scen_t;

   bpsk_frame_sched #(
      .FRAME_LEN(FL), .PREAMBLE_LEN(PL), .GAP_BAUDS(GB)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .base_addr(base_addr),
      .repeat_cnt(repeat_cnt), .baud_tick(baud_tick), .byte_req(byte_req),
      .byte_out(byte_out), .byte_valid(byte_valid), .ram_en(ram_en), .ram_addr(ram_addr),
      .ram_rd_data(ram_rd_data), .tx_en(tx_en), .busy(busy), .done(done),
      .frame_cnt(frame_cnt), .ovr(ovr)
   );

   always #5 clk = ~clk;

   // Synchronous-read frame RAM.
   always @(posedge clk) if (ram_en) ram_rd_data <= mem[ram_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bit-serial CRC-16-CCITT reference.
   function automatic logic [15:0] crc_ref(input logic [7:0] base);
      logic [15:0] c = 16'hFFFF;
      for (int i = 0; i < int'(FL); i++) begin
         logic [7:0] b = mem[8'(base + 8'(i))];
         for (int k = 7; k >= 0; k--) begin
            logic fb = c[15] ^ b[k];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   // Expected byte stream of one frame.
   function automatic void build_frame(input logic [7:0] base);
      logic [15:0] c;
      exp_q.delete();
      for (int i = 0; i < int'(PL); i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'h1A);
      exp_q.push_back(8'hCF);
      for (int i = 0; i < int'(FL); i++) exp_q.push_back(mem[8'(base + 8'(i))]);
      if (CL != 0) begin
         c = crc_ref(base);
         exp_q.push_back(c[15:8]);
         exp_q.push_back(c[7:0]);
      end
   endfunction

   // One byte request with latency, address and data checks.
   task automatic send_byte(input logic [7:0] exp_b, input bit is_pay, input logic [7:0] exp_addr,
                            input bit dbl, input bit do_stop);
      byte_req = 1'b1;
      stop     = do_stop;
      @(negedge clk);
      byte_req = dbl;
      stop     = 1'b0;
      start    = 1'b0;
      chk("valid_t1", byte_valid, 1'b0);
      chk("ram_en", ram_en, is_pay);
      if (is_pay) chk("ram_addr", ram_addr, exp_addr);
      @(negedge clk);
      byte_req = 1'b0;
      chk("valid_t2", byte_valid, 1'b1);
      chk("byte_out", byte_out, exp_b);
      rx_q.push_back(byte_out);
      if (dbl) chk("ovr_set", ovr, 1'b1);
      repeat ($urandom_range(1, 3)) begin
         baud_tick = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("no_extra_valid", byte_valid, 1'b0);
      end
      baud_tick = 1'b0;
   endtask

   task automatic run_scenario(input scen_t s);
      int  f = 0;
      bit  fin = 1'b0;
      bit  stop_sent = 1'b0;
      int  nb;
      bit  is_pay, dbl, dst;
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      @(negedge clk);
      base_addr  = s.base;
      repeat_cnt = s.rep;
      start      = 1'b1;
      stop       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      chk("start_busy", busy, 1'b1);
      chk("start_tx_en", tx_en, 1'b1);
      chk("start_ovr_clr", ovr, 1'b0);
      chk("start_fcnt_clr", frame_cnt, 8'd0);
      base_addr  = ~s.base;
      repeat_cnt = 8'd1;
      rx_q.delete();
      while (!fin && f < 8) begin
         build_frame(s.base);
         nb = exp_q.size();
         for (int i = 0; i < nb; i++) begin
            is_pay = (i >= int'(PL + 2)) && (i < int'(PL + 2 + FL));
            dbl    = s.dbl && (f == 0) && (i == int'(PL + 3));
            dst    = (s.stop_frame == f + 1) && (i == int'(PL + 3));
            if (f == 0 && i == 0) start = 1'b1;
            send_byte(exp_q[i], is_pay, 8'(s.base + 8'(i - int'(PL) - 2)), dbl, dst);
            if (dst) stop_sent = 1'b1;
         end
         byte_req = 1'b1;
         @(negedge clk);
         byte_req = 1'b0;
         f++;
         chk("eof_tx_en", tx_en, 1'b0);
         chk("eof_valid", byte_valid, 1'b0);
         chk("eof_fcnt", frame_cnt, 8'(f));
         @(negedge clk);
         chk("eof_valid2", byte_valid, 1'b0);
         fin = stop_sent || ((s.rep != 8'd0) && (f == int'(s.rep)));
         for (int t = 1; t <= int'(GB); t++) begin
            repeat ($urandom_range(0, 2)) begin
               byte_req = 1'($urandom_range(0, 1));
               @(negedge clk);
               byte_req = 1'b0;
            end
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
            if (t < int'(GB)) begin
               chk("gap_tx_en", tx_en, 1'b0);
               chk("gap_busy", busy, 1'b1);
               chk("gap_done", done, 1'b0);
               chk("gap_valid", byte_valid, 1'b0);
            end else if (fin) begin
               chk("end_busy", busy, 1'b0);
               chk("end_done", done, 1'b1);
            end else begin
               chk("next_tx_en", tx_en, 1'b1);
               chk("next_done", done, 1'b0);
            end
         end
      end
      chk("final_fcnt", frame_cnt, s.exp_frames);
      chk("final_ovr", ovr, s.exp_ovr);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
   endtask

   scen_t tbl[4];

   initial begin
      tbl[0] = '{base: 8'hFE, rep: 8'd1, stop_frame: 0, dbl: 1'b0, exp_frames: 8'd1, exp_ovr: 1'b0};
      tbl[1] = '{base: 8'h10, rep: 8'd3, stop_frame: 0, dbl: 1'b1, exp_frames: 8'd3, exp_ovr: 1'b1};
      tbl[2] = '{base: 8'hF0, rep: 8'd0, stop_frame: 2, dbl: 1'b0, exp_frames: 8'd2, exp_ovr: 1'b0};
      tbl[3] = '{base: 8'($urandom), rep: 8'd2, stop_frame: 1, dbl: 1'b0, exp_frames: 8'd1, exp_ovr: 1'b0};

      rst = 1'b1; start = 1'b0; stop = 1'b0; baud_tick = 1'b0; byte_req = 1'b0;
      base_addr = 8'h00; repeat_cnt = 8'h00;
      for (int k = 0; k < 256; k++) mem[k] = 8'(k);
      @(negedge clk);
      @(negedge clk);
      chk("rst_byte_out", byte_out, 8'h00);
      chk("rst_valid", byte_valid, 1'b0);
      chk("rst_ram_en", ram_en, 1'b0);
      chk("rst_ram_addr", ram_addr, 8'h00);
      chk("rst_tx_en", tx_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_fcnt", frame_cnt, 8'h00);
      chk("rst_ovr", ovr, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      for (int r = 0; r < 4; r++) begin
         if (r > 0) for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
`ifdef BPSK_SCHED_CRC_EN
         if (r == 0) for (int k = 0; k < 9; k++) mem[8'(8'hFE + 8'(k))] = 8'(8'h31 + 8'(k));
`endif
         run_scenario(tbl[r]);
`ifdef BPSK_SCHED_CRC_EN
         if (r == 0) begin
            chk("crc_hi", rx_q[rx_q.size() - 2], 8'h29);
            chk("crc_lo", rx_q[rx_q.size() - 1], 8'hB1);
         end
`else
         if (r == 0) begin
            chk("seq_pay0", rx_q[4], 8'hFE);
            chk("seq_pay3", rx_q[7], 8'h01);
         end
`endif
      end

      // Reset in the middle of the sync word aborts without a done pulse.
      base_addr = 8'h20; repeat_cnt = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      build_frame(8'h20);
      for (int i = 0; i < int'(PL + 1); i++) send_byte(exp_q[i], 1'b0, 8'h00, 1'b0, 1'b0);
      byte_req = 1'b1;
      @(negedge clk);
      byte_req = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_tx_en", tx_en, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_valid", byte_valid, 1'b0);
      chk("arst_byte_out", byte_out, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_done", done, 1'b0);
         chk("post_rst_valid", byte_valid, 1'b0);
      end
      for (int k = 0; k < 256; k++) mem[k] = 8'(k);
      run_scenario(tbl[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bpsk_frame_sched.md
# bpsk_frame_sched

Frame scheduler for the BPSK transmit path. On a start request it sequences one or more frames into the byte-serial modulator front end: preamble bytes, a 16-bit sync word, then a fixed-length payload read from the frame RAM, then a baud-counted guard gap. It sits between the PS-side control registers and the bit serializer/phase controller. It owns the RAM read port and the transmitter enable.

## Interface
- DATA_WIDTH, 8: RAM and byte width.
- ADDR_WIDTH, 8: frame RAM address width.
- FRAME_LEN, 150: payload bytes per frame, 1..2^ADDR_WIDTH.
- PREAMBLE_LEN, 4: preamble byte count, ≥1.
- PREAMBLE_BYTE, 8'h55: preamble pattern.
- SYNC_WORD, 16'h1ACF: sync word, sent MSB byte first.
- GAP_BAUDS, 32: guard length in baud ticks, ≥1.
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- start  in  1  one-cycle request; honoured only in IDLE.
- stop  in  1  one-cycle request; finish the current frame, then go to IDLE.
- base_addr  in  ADDR_WIDTH  payload start address, latched on an accepted start.
- repeat_cnt  in  8  frames per start, latched on an accepted start; 0 means continuous until stop.
- baud_tick  in  1  one-cycle baud strobe from the baud generator.
- byte_req  in  1  serializer pulse requesting the next byte.
- byte_out  out  DATA_WIDTH  byte to serializer.
- byte_valid  out  1  one-cycle qualifier for byte_out.
- ram_en  out  1  RAM read enable.
- ram_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM data, valid 1 cycle after ram_en.
- tx_en  out  1  modulator enable (gen_en / send gating).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- frame_cnt  out  8  frames completed since the last start; wraps at 255.
- ovr  out  1  sticky flag: byte_req arrived while a byte was still pending; cleared by start.

## Operation
- States: IDLE, PRE, SYNC, PAY, (CRC), GAP.
- IDLE + start: latch base_addr and repeat_cnt, clear frame_cnt and ovr, go to PRE, tx_en=1. A start outside IDLE is ignored.
- Byte issue, uniform in every byte state: a byte_req accepted in cycle T gives byte_valid=1 in cycle T+2. The pending flag is set at T and cleared at T+2. A byte_req while pending sets ovr and is otherwise dropped.
- PRE: issue PREAMBLE_BYTE PREAMBLE_LEN times, then go to SYNC.
- SYNC: issue SYNC_WORD[15:8], then SYNC_WORD[7:0], then go to PAY.
- PAY: each request drives ram_en=1 and ram_addr=base+idx in cycle T+1, and byte_out=ram_rd_data at T+2. idx runs 0..FRAME_LEN-1; the address wraps modulo 2^ADDR_WIDTH.
- End of frame: the first byte_req after the last payload (or CRC) byte gets no byte_valid. It moves the FSM to GAP, drops tx_en, and increments frame_cnt.
- GAP: count GAP_BAUDS baud_ticks, then decide:
  - stop seen during the frame or gap → IDLE;
  - repeat_cnt≠0 and frame_cnt==repeat_cnt → IDLE;
  - otherwise → PRE, tx_en=1.
- stop: latched in a stop_pend flag, cleared on entry to IDLE. If stop arrives in IDLE it is ignored. If stop and start arrive in the same cycle in IDLE, start wins and stop is ignored.

## Timing
- Reset values: byte_out=0, byte_valid=0, ram_en=0, ram_addr=0, tx_en=0, busy=0, done=0, frame_cnt=0, ovr=0, state=IDLE.
- Reset mid-frame aborts at once. done does not pulse.
- start→busy/tx_en: 1 cycle.
- byte_req→byte_valid: exactly 2 cycles in all states.
- GAP exit: the cycle after the GAP_BAUDS-th baud_tick.
- done: one cycle, coincident with busy falling.
- byte_req in IDLE or GAP: ignored, no ovr.
- baud_tick outside GAP: ignored.

## Configuration
- BPSK_SCHED_CRC_EN defined:
  - After PAY, a CRC state issues CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection) over the payload bytes, MSB byte first.
  - The CRC is updated on each payload byte_valid.
  - The CRC is reset on entry to PRE.
- BPSK_SCHED_CRC_EN undefined:
  - No CRC state or logic.
  - PAY ends directly into the end-of-frame path.

## Structure
- Package bpsk_sched_pkg: state enum, CRC poly/init constants, default PREAMBLE_BYTE and SYNC_WORD.
- Sub-module bpsk_crc16: byte-wise combinational-next/registered CRC with clear and enable. Instantiated only under BPSK_SCHED_CRC_EN.

## Test plan
- Single frame: FRAME_LEN=4, PREAMBLE_LEN=2, base_addr=8'hFE, RAM[k]=k, repeat_cnt=1, CRC off.
  - Bytes must be 55,55,1A,CF,FE,FF,00,01.
  - ram_addr must wrap FE→FF→00→01.
  - After GAP_BAUDS ticks: done pulse, frame_cnt=1.
- Latency: for every byte, byte_valid fires exactly 2 cycles after byte_req. A second byte_req 1 cycle after the first sets ovr=1 and the byte stream is unchanged.
- repeat_cnt=3: three frames, each separated by exactly GAP_BAUDS baud_ticks with tx_en=0; done after the third; frame_cnt=3.
- Continuous mode: repeat_cnt=0, stop asserted mid-PAY of frame 2. Frame 2 completes, then GAP, then IDLE, with frame_cnt=2.
- rst asserted in SYNC: all outputs take reset values asynchronously and no done pulse. A later start gives a normal frame.
- With BPSK_SCHED_CRC_EN and payload "123456789": the trailing bytes are 29, B1.
